// File: rtl/run_extrema_pkg.sv
// Shared types and widths for the run extrema tracker.
// State encoding plus sample and counter widths.
package run_extrema_pkg;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        TRACK  = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/run_extrema_cmp4_core.sv
// Combinational unsigned magnitude comparator.
// Flags a < b, a > b and a == b.
module cmp4_core
    import run_extrema_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              lt,
    output logic              gt,
    output logic              eq
);

    assign lt = (a < b);
    assign gt = (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/run_extrema_tracker.sv
// Windowed running max/min tracker with a valid/ready report handshake.
// Optional eq_cnt output enabled by RUN_EXTREMA_EQ_CNT_EN.
module run_extrema_tracker
    import run_extrema_pkg::*;
#(
    parameter int WIN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] max_val,
    output logic [DATA_W-1:0] min_val,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic              new_max,
    output logic              new_min
`ifdef RUN_EXTREMA_EQ_CNT_EN
    ,
    output logic [DATA_W-1:0] eq_cnt
`endif
);

    localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WIN);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [CNT_W-1:0] cnt_inc;
    logic             max_lt;
    logic             max_gt;
    logic             max_eq;
    logic             min_lt;
    logic             min_gt;
    logic             min_eq;
    logic             cmp_unused;

    cmp4_core u_cmp_max (
        .a  (in_data),
        .b  (max_val),
        .lt (max_lt),
        .gt (max_gt),
        .eq (max_eq)
    );

    cmp4_core u_cmp_min (
        .a  (in_data),
        .b  (min_val),
        .lt (min_lt),
        .gt (min_gt),
        .eq (min_eq)
    );

    assign cmp_unused = ^{max_lt, min_gt, min_eq, max_eq};

    assign in_ready  = (state != REPORT);
    assign out_valid = (state == REPORT);
    assign accept    = in_valid && in_ready && !clr;
    assign cnt_inc   = sample_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = (WIN == 1) ? REPORT : TRACK;
                end
            end
            TRACK: begin
                if (accept && cnt_inc == WIN_C) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (clr) begin
            state_nxt = EMPTY;
        end
    end

    // Extrema survive a consumed report; only clr and reset zero them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_val    <= '0;
            min_val    <= '0;
            sample_cnt <= '0;
            new_max    <= 1'b0;
            new_min    <= 1'b0;
        end else begin
            new_max <= 1'b0;
            new_min <= 1'b0;
            if (clr) begin
                max_val    <= '0;
                min_val    <= '0;
                sample_cnt <= '0;
            end else if (state == REPORT) begin
                if (out_ready) begin
                    sample_cnt <= '0;
                end
            end else if (accept) begin
                if (state == EMPTY) begin
                    max_val    <= in_data;
                    min_val    <= in_data;
                    sample_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    if (max_gt) begin
                        max_val <= in_data;
                        new_max <= 1'b1;
                    end
                    if (min_lt) begin
                        min_val <= in_data;
                        new_min <= 1'b1;
                    end
                    sample_cnt <= cnt_inc;
                end
            end
        end
    end

`ifdef RUN_EXTREMA_EQ_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_cnt <= '0;
        end else if (clr || state == EMPTY ||
                     (state == REPORT && out_ready)) begin
            eq_cnt <= '0;
        end else if (accept && state == TRACK && max_eq &&
                     eq_cnt != 4'hF) begin
            eq_cnt <= eq_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_run_extrema_tracker.sv
// Self-checking bench for run_extrema_tracker (WIN=4 and WIN=1 instances).
// Table vectors, corner sequences and a queue-based random reference model.
module tb_run_extrema_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] max_val;
    logic [3:0] min_val;
    logic [7:0] sample_cnt;
    logic       new_max;
    logic       new_min;

    logic       in_valid1;
    logic       in_ready1;
    logic [3:0] in_data1;
    logic       out_valid1;
    logic       out_ready1;
    logic [3:0] max_val1;
    logic [3:0] min_val1;
    logic [7:0] sample_cnt1;
    logic       new_max1;
    logic       new_min1;
`ifdef RUN_EXTREMA_EQ_CNT_EN
    logic [3:0] eq_cnt;
    logic [3:0] eq_cnt1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    run_extrema_tracker #(.WIN(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .max_val    (max_val),
        .min_val    (min_val),
        .sample_cnt (sample_cnt),
        .new_max    (new_max),
        .new_min    (new_min)
`ifdef RUN_EXTREMA_EQ_CNT_EN
        ,
        .eq_cnt     (eq_cnt)
`endif
    );

    run_extrema_tracker #(.WIN(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (1'b0),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .in_data    (in_data1),
        .out_valid  (out_valid1),
        .out_ready  (out_ready1),
        .max_val    (max_val1),
        .min_val    (min_val1),
        .sample_cnt (sample_cnt1),
        .new_max    (new_max1),
        .new_min    (new_min1)
`ifdef RUN_EXTREMA_EQ_CNT_EN
        ,
        .eq_cnt     (eq_cnt1)
`endif
    );

    // Reference model: the current window is simply the list of samples.
    int q[$];
    int m_max;
    int m_min;
    bit m_rep;
    bit m_pmax;
    bit m_pmin;

    function automatic int qmax(input int upto);
        int r = 0;
        for (int i = 0; i < upto; i++) if (q[i] > r) r = q[i];
        return r;
    endfunction

    function automatic int qmin(input int upto);
        int r = 15;
        for (int i = 0; i < upto; i++) if (q[i] < r) r = q[i];
        return r;
    endfunction

    function automatic int qeq();
        int e = 0;
        for (int i = 1; i < q.size(); i++)
            if (q[i] == qmax(i) && e < 15) e++;
        return e;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_max  = 0;
        m_min  = 0;
        m_rep  = 0;
        m_pmax = 0;
        m_pmin = 0;
    endfunction

    function automatic void model_step(input bit c, input bit v,
                                       input int d, input bit r);
        m_pmax = 0;
        m_pmin = 0;
        if (c) begin
            model_reset();
        end else if (m_rep) begin
            if (r) begin
                q.delete();
                m_rep = 0;
            end
        end else if (v) begin
            if (q.size() > 0) begin
                m_pmax = d > qmax(q.size());
                m_pmin = d < qmin(q.size());
            end
            q.push_back(d);
            m_max = qmax(q.size());
            m_min = qmin(q.size());
            if (q.size() == 4) m_rep = 1;
        end
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit c, input bit v,
                       input logic [3:0] d, input bit r);
        @(negedge clk);
        clr       = c;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        model_step(c, v, int'(d), r);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " max"}, int'(max_val), m_max);
        chk({tag, " min"}, int'(min_val), m_min);
        chk({tag, " cnt"}, int'(sample_cnt), q.size());
        chk({tag, " out_valid"}, int'(out_valid), int'(m_rep));
        chk({tag, " in_ready"}, int'(in_ready), int'(!m_rep));
        chk({tag, " new_max"}, int'(new_max), int'(m_pmax));
        chk({tag, " new_min"}, int'(new_min), int'(m_pmin));
`ifdef RUN_EXTREMA_EQ_CNT_EN
        chk({tag, " eq_cnt"}, int'(eq_cnt), qeq());
`endif
    endtask

    typedef struct {
        bit         c;
        bit         v;
        logic [3:0] d;
        bit         r;
        int         mx;
        int         mn;
        int         cnt;
        bit         ov;
        bit         nmx;
        bit         nmn;
        int         eq;
    } vec_t;

    vec_t tv[10];

    initial begin
        tv[0] = '{0, 1, 4'd5,  1, 5,  5, 1, 0, 0, 0, 0};
        tv[1] = '{0, 1, 4'd9,  1, 9,  5, 2, 0, 1, 0, 0};
        tv[2] = '{0, 1, 4'd2,  1, 9,  2, 3, 0, 0, 1, 0};
        tv[3] = '{0, 1, 4'd9,  1, 9,  2, 4, 1, 0, 0, 1};
        tv[4] = '{0, 1, 4'd7,  1, 9,  2, 0, 0, 0, 0, 0};
        tv[5] = '{0, 1, 4'd3,  0, 3,  3, 1, 0, 0, 0, 0};
        tv[6] = '{0, 1, 4'd7,  0, 7,  3, 2, 0, 1, 0, 0};
        tv[7] = '{0, 1, 4'd12, 0, 12, 3, 3, 0, 1, 0, 0};
        tv[8] = '{1, 1, 4'd4,  0, 0,  0, 0, 0, 0, 0, 0};
        tv[9] = '{0, 1, 4'd4,  0, 4,  4, 1, 0, 0, 0, 0};

        rst_n      = 1'b0;
        clr        = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_data1   = '0;
        out_ready1 = 1'b0;
        model_reset();

        #12;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset max", int'(max_val), 0);
        chk("reset min", int'(min_val), 0);
        chk("reset cnt", int'(sample_cnt), 0);
        #10 rst_n = 1'b1;

        foreach (tv[i]) begin
            cyc(tv[i].c, tv[i].v, tv[i].d, tv[i].r);
            chk($sformatf("vec%0d max", i), int'(max_val), tv[i].mx);
            chk($sformatf("vec%0d min", i), int'(min_val), tv[i].mn);
            chk($sformatf("vec%0d cnt", i), int'(sample_cnt), tv[i].cnt);
            chk($sformatf("vec%0d ov", i), int'(out_valid), int'(tv[i].ov));
            chk($sformatf("vec%0d ir", i), int'(in_ready), int'(!tv[i].ov));
            chk($sformatf("vec%0d nmax", i), int'(new_max), int'(tv[i].nmx));
            chk($sformatf("vec%0d nmin", i), int'(new_min), int'(tv[i].nmn));
`ifdef RUN_EXTREMA_EQ_CNT_EN
            chk($sformatf("vec%0d eq", i), int'(eq_cnt), tv[i].eq);
`endif
        end

        // Backpressure in REPORT: nothing accepted, outputs frozen.
        cyc(1, 0, 4'd0, 0);
        cyc(0, 1, 4'd1, 0);
        cyc(0, 1, 4'd8, 0);
        cyc(0, 1, 4'd8, 0);
        cyc(0, 1, 4'd0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 4'd15, 0);
            chk("hold ov", int'(out_valid), 1);
            chk("hold ir", int'(in_ready), 0);
            chk("hold max", int'(max_val), 8);
            chk("hold min", int'(min_val), 0);
            chk("hold cnt", int'(sample_cnt), 4);
        end
        cyc(0, 1, 4'd15, 1);
        chk("release ov", int'(out_valid), 0);
        chk("release cnt", int'(sample_cnt), 0);
        chk("release max", int'(max_val), 8);
        chk("release min", int'(min_val), 0);

        // Asynchronous reset while a report is pending.
        cyc(0, 1, 4'd3, 0);
        cyc(0, 1, 4'd4, 0);
        cyc(0, 1, 4'd5, 0);
        cyc(0, 1, 4'd6, 0);
        chk("pre-rst ov", int'(out_valid), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst ov", int'(out_valid), 0);
        chk("arst ir", int'(in_ready), 1);
        chk("arst max", int'(max_val), 0);
        chk("arst min", int'(min_val), 0);
        chk("arst cnt", int'(sample_cnt), 0);
        chk("arst nmax", int'(new_max), 0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc(0, 1, 4'd6, 0);
        chk("post-rst max", int'(max_val), 6);
        chk("post-rst min", int'(min_val), 6);
        chk("post-rst cnt", int'(sample_cnt), 1);
        chk("post-rst nmax", int'(new_max), 0);

        // WIN=1 goes straight to REPORT with no pulses.
        @(negedge clk);
        in_valid1 = 1'b1;
        in_data1  = 4'd15;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        chk("w1 ov", int'(out_valid1), 1);
        chk("w1 ir", int'(in_ready1), 0);
        chk("w1 max", int'(max_val1), 15);
        chk("w1 min", int'(min_val1), 15);
        chk("w1 cnt", int'(sample_cnt1), 1);
        chk("w1 nmax", int'(new_max1), 0);
        chk("w1 nmin", int'(new_min1), 0);
`ifdef RUN_EXTREMA_EQ_CNT_EN
        chk("w1 eq", int'(eq_cnt1), 0);
`endif

        // Randomised traffic against the window-list model.
        cyc(1, 0, 4'd0, 0);
        chk_model("rnd clr");
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 19) == 0,
                $urandom_range(0, 3) != 0,
                4'($urandom_range(0, 15)),
                $urandom_range(0, 2) == 0);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_extrema_tracker.md
RUN_EXTREMA_TRACKER -- requirements
Module: run_extrema_tracker

Interface
REQ-001 SHALL have parameter WIN, default 8, meaning samples per report window (legal range 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port clr  input  1  synchronous clear of the current window.
REQ-005 SHALL have port in_valid  input  1  upstream sample valid.
REQ-006 SHALL have port in_ready  output  1  tracker can accept a sample.
REQ-007 SHALL have port in_data  input  4  unsigned sample.
REQ-008 SHALL have port out_valid  output  1  window summary available.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the summary.
REQ-010 SHALL have port max_val  output  4  running maximum of the window.
REQ-011 SHALL have port min_val  output  4  running minimum of the window.
REQ-012 SHALL have port sample_cnt  output  8  samples accepted in the current window.
REQ-013 SHALL have ports new_max and new_min  output  1 each  one-cycle registered pulses on a strict extremum update.

Function
REQ-014 SHALL implement states EMPTY, TRACK and REPORT; in_ready = 1 in EMPTY/TRACK and 0 in REPORT; out_valid = 1 only in REPORT.
REQ-015 SHALL accept a sample exactly when in_valid and in_ready are both 1 at a rising edge.
REQ-016 In EMPTY, an accepted sample SHALL load max_val = min_val = in_data and sample_cnt = 1, pulse neither new_max nor new_min, and go to TRACK (or to REPORT if WIN = 1).
REQ-017 In TRACK, an accepted sample SHALL be compared unsigned against max_val and min_val.
REQ-018 If the sample is strictly greater than max_val, max_val SHALL take the sample and new_max SHALL pulse in the following cycle.
REQ-019 If the sample is strictly less than min_val, min_val SHALL take the sample and new_min SHALL pulse in the following cycle.
REQ-020 If the sample equals an extremum, that extremum SHALL be unchanged with no pulse; sample_cnt SHALL increment by 1.
REQ-021 max_val, min_val and sample_cnt SHALL be visible the cycle after acceptance (latency 1); the acceptance that makes sample_cnt = WIN SHALL move to REPORT, with out_valid high the next cycle.
REQ-022 In REPORT, outputs SHALL hold stable until out_ready = 1; that edge SHALL go to EMPTY with sample_cnt = 0, max_val and min_val retained, and no sample accepted on that edge.
REQ-023 clr = 1 SHALL take priority over all events: go to EMPTY, sample_cnt = 0, max_val = min_val = 0, pulses deasserted, and any concurrent sample discarded.
REQ-024 sample_cnt SHALL never exceed WIN; no wrap-around is permitted.

Reset
REQ-025 rst_n low SHALL immediately force state EMPTY, max_val = 0, min_val = 0, sample_cnt = 0, new_max = new_min = 0, out_valid = 0 and in_ready = 1, independent of clk.
REQ-026 Reset asserted in any state, including REPORT, SHALL discard the pending summary; operation SHALL resume on the first rising edge after rst_n rises.

Configuration
REQ-027 Macro RUN_EXTREMA_EQ_CNT_EN defined SHALL add output eq_cnt (4 bits).
REQ-028 eq_cnt SHALL count accepted TRACK samples equal to the current max_val, saturate at 15, and reset to 0 on EMPTY, clr or rst_n.
REQ-029 Without RUN_EXTREMA_EQ_CNT_EN, the eq_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package run_extrema_pkg SHALL hold the state encoding (EMPTY/TRACK/REPORT), DATA_W = 4 and CNT_W = 8.
REQ-031 Magnitude comparison SHALL use sub-module cmp4_core (combinational 4-bit lt/gt/eq), instantiated twice: sample vs max_val and sample vs min_val.

Verification
REQ-032 WIN=4, samples 5,9,2,9, out_ready=1 -> out_valid one cycle after 4th sample, max_val=9, min_val=2, new_max once (after first 9), new_min once, eq_cnt=1 with macro.
REQ-033 WIN=4, out_ready held 0 for 3 cycles in REPORT while in_valid=1 -> in_ready=0, outputs constant, no sample accepted; then out_ready=1 -> EMPTY, sample_cnt=0.
REQ-034 WIN=8, clr asserted with in_valid=1 after 3 samples (7,3,12) -> next cycle EMPTY, sample_cnt=0, max_val=min_val=0, concurrent sample dropped.
REQ-035 rst_n pulled low mid-cycle in REPORT -> outputs at reset values before next clk edge; first post-reset sample 6 -> max_val=min_val=6, sample_cnt=1.
REQ-036 WIN=1, sample 15 -> REPORT directly, max_val=min_val=15, no new_max/new_min pulse.
